// File: rtl/ctr_table_ctrl.sv
// ctr_table_ctrl: clears a 1024x20 2-bit counter-table SRAM, then arbitrates lookups against buffered lane updates.
// Optional macro CTR_TABLE_BYPASS_EN overlays pending FIFO updates onto lookup responses.
module ctr_table_ctrl #(
    parameter int DEPTH = 1024,
    parameter int LANES = 10,
    parameter logic [1:0] INIT_VAL = 2'b01,
    parameter int UFIFO_D = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(LANES),
    localparam int RW = 2 * LANES
) (
    input  logic          RW0_clk,
    input  logic          reset,
    input  logic          lk_valid,
    output logic          lk_ready,
    input  logic [AW-1:0] lk_addr,
    output logic          rsp_valid,
    output logic [RW-1:0] rsp_ctrs,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [AW-1:0] up_addr,
    input  logic [LW-1:0] up_lane,
    input  logic          up_taken,
    input  logic [1:0]    up_old,
    output logic [AW-1:0] mem_addr,
    output logic          mem_en,
    output logic          mem_wmode,
    output logic [LANES-1:0] mem_wmask,
    output logic [RW-1:0] mem_wdata,
    input  logic [RW-1:0] mem_rdata,
    output logic          busy_init
);
    localparam int CW = $clog2(UFIFO_D + 1);

    typedef enum logic {INIT, RUN} state_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] lane;
        logic [1:0]    nxt;
    } ent_t;

    state_t state, state_n;
    logic [AW-1:0] init_cnt;
    ent_t fifo [UFIFO_D];
    ent_t head, up_ent;
    logic [CW-1:0] cnt;
    logic run, full, enq, deq, lk_fire, rsp_q;
    logic [1:0] up_next;

    assign run = (state == RUN) & ~reset;
    assign full = cnt == CW'(UFIFO_D);
    assign head = fifo[0];
    assign busy_init = (state == INIT) | reset;
    assign lk_ready = run & ~full;
    assign up_ready = run & ~full;
    assign lk_fire = lk_valid & lk_ready;
    // Out-of-range lanes are handshaken but never enqueued.
    assign enq = up_valid & up_ready & ({1'b0, up_lane} < (LW + 1)'(LANES));
    assign deq = run & (cnt != '0) & (full | ~lk_valid);
    assign up_next = up_taken ? (up_old == 2'd3 ? 2'd3 : up_old + 2'd1)
                              : (up_old == 2'd0 ? 2'd0 : up_old - 2'd1);
    assign up_ent = '{addr: up_addr, lane: up_lane, nxt: up_next};
    assign rsp_valid = rsp_q & ~reset;

    always_comb begin
        state_n = state;
        if (state == INIT && init_cnt == AW'(DEPTH - 1)) state_n = RUN;
    end

    always_ff @(posedge RW0_clk) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
            cnt      <= '0;
            rsp_q    <= 1'b0;
        end else begin
            state    <= state_n;
            init_cnt <= (state == INIT) ? init_cnt + 1'b1 : '0;
            cnt      <= cnt + CW'(enq) - CW'(deq);
            rsp_q    <= lk_fire;
        end
    end

    // Shift-register FIFO: entry 0 is always the head.
    always_ff @(posedge RW0_clk) begin
        if (deq) for (int i = 0; i < UFIFO_D - 1; i++) fifo[i] <= fifo[i + 1];
        for (int i = 0; i < UFIFO_D; i++)
            if (enq && CW'(i) == cnt - CW'(deq)) fifo[i] <= up_ent;
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (!reset && state == INIT) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_wmask = '1;
            mem_wdata = {LANES{INIT_VAL}};
            mem_addr  = init_cnt;
        end else if (lk_fire) begin
            mem_en   = 1'b1;
            mem_addr = lk_addr;
        end else if (deq) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = head.addr;
            mem_wmask = LANES'(1) << head.lane;
            mem_wdata = RW'(head.nxt) << {head.lane, 1'b0};
        end
    end

`ifdef CTR_TABLE_BYPASS_EN
    logic [RW-1:0] byp_msk, byp_msk_n, byp_val, byp_val_n;

    // Oldest to youngest, so later entries overwrite earlier ones on the same lane.
    always_comb begin
        byp_msk_n = '0;
        byp_val_n = '0;
        for (int i = 0; i < UFIFO_D; i++)
            if (CW'(i) < cnt && fifo[i].addr == lk_addr) begin
                byp_msk_n = byp_msk_n | (RW'(3) << {fifo[i].lane, 1'b0});
                byp_val_n = (byp_val_n & ~(RW'(3) << {fifo[i].lane, 1'b0})) | (RW'(fifo[i].nxt) << {fifo[i].lane, 1'b0});
            end
        if (enq && up_addr == lk_addr) begin
            byp_msk_n = byp_msk_n | (RW'(3) << {up_lane, 1'b0});
            byp_val_n = (byp_val_n & ~(RW'(3) << {up_lane, 1'b0})) | (RW'(up_next) << {up_lane, 1'b0});
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (lk_fire) begin
            byp_msk <= byp_msk_n;
            byp_val <= byp_val_n;
        end
    end

    assign rsp_ctrs = (mem_rdata & ~byp_msk) | byp_val;
`else
    assign rsp_ctrs = mem_rdata;
`endif
endmodule
